instr_decoder_pipe: RTL and testbench
=====================================

Name: instr_decoder_pipe

Overview:
Parametrised, registered successor to the nibble-switch instruction decoder for the 16-bit, 4-nibble (CHIP-8 style) ISA.
- Accepts instruction words, or byte pairs with the high byte first, through a valid/ready input tagged with PC.
- Fully decodes the word into an opcode enum plus operand fields and flags illegal encodings.
- Presents the result through a registered valid/ready output to the execute stage, and sits between the fetch unit and execute.

Parameters:
FETCH_W, 16, input beat width; legal values are 16 (one beat per instruction) and 8 (two beats, high byte first).
PC_W, 12, width of the PC tag.
STRICT, 0, 1 = any 0nnn other than 00E0/00EE is illegal; 0 = it decodes as OP_SYS.
CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  synchronous pipeline flush.
in_valid  in  1  input beat valid.
in_ready  out  1  input beat accepted when in_valid&&in_ready.
in_data  in  FETCH_W  instruction word, or byte (high byte first).
in_pc  in  PC_W  PC of the instruction; sampled on the first beat.
out_valid  out  1  decoded instruction valid.
out_ready  in  1  consumer accepts the decoded instruction.
out_op  out  6  opcode enum (op_e).
out_x  out  4  nibble [11:8].
out_y  out  4  nibble [7:4].
out_n  out  4  nibble [3:0].
out_nn  out  8  bits [7:0].
out_nnn  out  12  bits [11:0].
out_instr  out  16  raw instruction word.
out_pc  out  PC_W  PC tag.
out_illegal  out  1  encoding is illegal; out_op = OP_NONE.
illegal_cnt  out  CNT_W  saturating count of illegal instructions loaded into the output register.

Behaviour:
Reset:
- rst is synchronous and active-high.
- Clears out_valid, all out_* fields, illegal_cnt and the byte-assembly state.
- out_op resets to OP_NONE (value 0).
- Reset mid-assembly discards any held byte.

Output register:
- Loaded when a completing beat is accepted.
- out_valid rises the next cycle; latency is 1 cycle from the completing beat.
- Fields hold stable while out_valid && !out_ready.
- out_valid clears on out_ready unless a new word loads in the same cycle (back-to-back throughput is 1 per cycle).

FETCH_W=16:
- Every beat is a completing beat.
- in_ready = !out_valid || out_ready (combinational from out_ready).

FETCH_W=8, two-state FSM:
- S_HI: in_ready=1. An accepted beat stores hi_q and pc_q, then moves to S_LO.
- S_LO: in_ready = !out_valid || out_ready. An accepted beat is a completing beat (word = {hi_q, in_data}, pc = pc_q), then returns to S_HI.

Flush:
- Clears out_valid, returns the FSM to S_HI and discards hi_q.
- Beats accepted in the same cycle are dropped; flush dominates both accept and out_ready.
- illegal_cnt is unaffected.

Decode (nibble0 selects the class):
- 0: 00E0 CLS, 00EE RET, otherwise SYS/illegal per STRICT.
- 1 JP, 2 CALL, 3 SE_IMM, 4 SNE_IMM, 5 SE_REG (n must be 0), 6 LD_IMM, 7 ADD_IMM.
- 8: n = 0..7 gives LD/OR/AND/XOR/ADD/SUB/SHR/SUBN; n = E gives SHL; any other n is illegal.
- 9: SNE_REG (n must be 0).
- A LD_I, B JP_V0, C RND, D DRW.
- E: nn = 9E gives SKP, nn = A1 gives SKNP; any other nn is illegal.
- F: nn = 07, 0A, 15, 18, 1E, 29, 33, 55, 65 each map to a distinct op; any other nn is illegal.

Field outputs:
- x, y, n, nn and nnn are always populated from the word, whether it is legal or illegal.

illegal_cnt:
- Increments by 1 on each load with illegal=1.
- Saturates at 2^CNT_W-1; no wrap.

Simultaneous events:
- Load and unload in the same cycle: the new word wins and the counter updates.

Decomposition:
Package decoder_pkg:
- op_e enum (6-bit, OP_NONE=0).
- Nibble-class constants, F/E sub-op constants.
- Parameter legality check: a FETCH_W other than 8 or 16 triggers an elaboration error.

Sub-module instr_decode_comb:
- Purely combinational word → {op, illegal}, parametrised by STRICT.
- Reused by the disassembler testbench model.

Test Plan:
1. FETCH_W=16, 16'h8AB4 at pc 0x200 → next cycle:
   - out_op=OP_ADD_REG, x=A, y=B, n=4, illegal=0, pc=0x200.
2. FETCH_W=8, beats D1 then 25 with in_pc=0x2F0 on the first beat → one cycle after beat 25:
   - OP_DRW, x=1, y=2, n=5, instr=D125, pc=0x2F0.
3. Backpressure: out_ready=0 with 6A42 held, then present 7105 → in_ready=0 and outputs stable. Raise out_ready →
   - 6A42 consumed, then OP_ADD_IMM x=1 nn=05 the following cycle.
4. Illegal handling:
   - Stream 5121, E1FF, 800F → three outputs with illegal=1, op=OP_NONE; illegal_cnt=3.
   - With CNT_W=2, a fifth illegal leaves illegal_cnt=3.
5. STRICT handling:
   - STRICT=1: 0123 → illegal.
   - STRICT=0: 0123 → OP_SYS, nnn=123.
   - 00E0 → OP_CLS under both settings.
6. FETCH_W=8 flush: accept A2, pulse flush, then feed 12 and 34 →
   - OP_JP, nnn=234, instr=1234; no A2xx word is emitted. Repeat with rst in place of flush and get the same result.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and encodings for the CHIP-8 style instruction decoder pipeline.
package decoder_pkg;

  typedef enum logic [5:0] {
    OP_NONE = 6'd0,
    OP_CLS, OP_RET, OP_SYS, OP_JP, OP_CALL,
    OP_SE_IMM, OP_SNE_IMM, OP_SE_REG, OP_LD_IMM, OP_ADD_IMM,
    OP_LD_REG, OP_OR, OP_AND, OP_XOR, OP_ADD_REG, OP_SUB, OP_SHR, OP_SUBN, OP_SHL,
    OP_SNE_REG, OP_LD_I, OP_JP_V0, OP_RND, OP_DRW, OP_SKP, OP_SKNP,
    OP_LD_VX_DT, OP_LD_VX_K, OP_LD_DT_VX, OP_LD_ST_VX, OP_ADD_I_VX,
    OP_LD_F_VX, OP_LD_B_VX, OP_LD_I_VX, OP_LD_VX_I
  } op_e;

  typedef enum logic {S_HI, S_LO} asm_state_e;

  // Instruction class selected by the top nibble.
  localparam logic [3:0] NIB_SYS     = 4'h0;
  localparam logic [3:0] NIB_JP      = 4'h1;
  localparam logic [3:0] NIB_CALL    = 4'h2;
  localparam logic [3:0] NIB_SE_IMM  = 4'h3;
  localparam logic [3:0] NIB_SNE_IMM = 4'h4;
  localparam logic [3:0] NIB_SE_REG  = 4'h5;
  localparam logic [3:0] NIB_LD_IMM  = 4'h6;
  localparam logic [3:0] NIB_ADD_IMM = 4'h7;
  localparam logic [3:0] NIB_ALU     = 4'h8;
  localparam logic [3:0] NIB_SNE_REG = 4'h9;
  localparam logic [3:0] NIB_LD_I    = 4'hA;
  localparam logic [3:0] NIB_JP_V0   = 4'hB;
  localparam logic [3:0] NIB_RND     = 4'hC;
  localparam logic [3:0] NIB_DRW     = 4'hD;
  localparam logic [3:0] NIB_KEY     = 4'hE;
  localparam logic [3:0] NIB_MISC    = 4'hF;

  localparam logic [15:0] INSTR_CLS = 16'h00E0;
  localparam logic [15:0] INSTR_RET = 16'h00EE;

  localparam logic [7:0] E_SKP  = 8'h9E;
  localparam logic [7:0] E_SKNP = 8'hA1;

  localparam logic [7:0] F_LD_VX_DT = 8'h07;
  localparam logic [7:0] F_LD_VX_K  = 8'h0A;
  localparam logic [7:0] F_LD_DT_VX = 8'h15;
  localparam logic [7:0] F_LD_ST_VX = 8'h18;
  localparam logic [7:0] F_ADD_I_VX = 8'h1E;
  localparam logic [7:0] F_LD_F_VX  = 8'h29;
  localparam logic [7:0] F_LD_B_VX  = 8'h33;
  localparam logic [7:0] F_LD_I_VX  = 8'h55;
  localparam logic [7:0] F_LD_VX_I  = 8'h65;

  function automatic bit fetch_w_legal(input int unsigned w);
    return (w == 8) || (w == 16);
  endfunction

endpackage

// File: rtl/instr_decode_comb.sv
// Combinational decode of one 16-bit instruction word into an opcode and an illegal flag.
module instr_decode_comb
  import decoder_pkg::*;
#(
  parameter bit STRICT = 1'b0
) (
  input  logic [15:0] instr_i,
  output op_e         op_o,
  output logic        illegal_o
);

  logic [3:0] n_w;
  logic [7:0] nn_w;

  assign n_w  = instr_i[3:0];
  assign nn_w = instr_i[7:0];

  // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    op_o = OP_NONE;
    case (instr_i[15:12])
      NIB_SYS: begin
        if (instr_i == INSTR_CLS)      op_o = OP_CLS;
        else if (instr_i == INSTR_RET) op_o = OP_RET;
        else if (!STRICT)              op_o = OP_SYS;
      end
      NIB_JP:      op_o = OP_JP;
      NIB_CALL:    op_o = OP_CALL;
      NIB_SE_IMM:  op_o = OP_SE_IMM;
      NIB_SNE_IMM: op_o = OP_SNE_IMM;
      NIB_SE_REG:  if (n_w == 4'h0) op_o = OP_SE_REG;
      NIB_LD_IMM:  op_o = OP_LD_IMM;
      NIB_ADD_IMM: op_o = OP_ADD_IMM;
      NIB_ALU: begin
        case (n_w)
          4'h0:    op_o = OP_LD_REG;
          4'h1:    op_o = OP_OR;
          4'h2:    op_o = OP_AND;
          4'h3:    op_o = OP_XOR;
          4'h4:    op_o = OP_ADD_REG;
          4'h5:    op_o = OP_SUB;
          4'h6:    op_o = OP_SHR;
          4'h7:    op_o = OP_SUBN;
          4'hE:    op_o = OP_SHL;
          default: op_o = OP_NONE;
        endcase
      end
      NIB_SNE_REG: if (n_w == 4'h0) op_o = OP_SNE_REG;
      NIB_LD_I:    op_o = OP_LD_I;
      NIB_JP_V0:   op_o = OP_JP_V0;
      NIB_RND:     op_o = OP_RND;
      NIB_DRW:     op_o = OP_DRW;
      NIB_KEY: begin
        case (nn_w)
          E_SKP:   op_o = OP_SKP;
          E_SKNP:  op_o = OP_SKNP;
          default: op_o = OP_NONE;
        endcase
      end
      NIB_MISC: begin
        case (nn_w)
          F_LD_VX_DT: op_o = OP_LD_VX_DT;
          F_LD_VX_K:  op_o = OP_LD_VX_K;
          F_LD_DT_VX: op_o = OP_LD_DT_VX;
          F_LD_ST_VX: op_o = OP_LD_ST_VX;
          F_ADD_I_VX: op_o = OP_ADD_I_VX;
          F_LD_F_VX:  op_o = OP_LD_F_VX;
          F_LD_B_VX:  op_o = OP_LD_B_VX;
          F_LD_I_VX:  op_o = OP_LD_I_VX;
          F_LD_VX_I:  op_o = OP_LD_VX_I;
          default:    op_o = OP_NONE;
        endcase
      end
      default: op_o = OP_NONE;
    endcase
    illegal_o = (op_o == OP_NONE);
  end

endmodule

// File: rtl/instr_decoder_pipe.sv
// Registered decode stage between fetch and execute; optionally assembles words from two byte beats.
module instr_decoder_pipe
  import decoder_pkg::*;
#(
  parameter int unsigned FETCH_W = 16,
  parameter int unsigned PC_W    = 12,
  parameter bit          STRICT  = 1'b0,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FETCH_W-1:0] in_data,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output op_e                out_op,
  output logic [3:0]         out_x,
  output logic [3:0]         out_y,
  output logic [3:0]         out_n,
  output logic [7:0]         out_nn,
  output logic [11:0]        out_nnn,
  output logic [15:0]        out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   illegal_cnt
);

  if (!fetch_w_legal(FETCH_W)) begin : g_bad_fetch_w
    $error("instr_decoder_pipe: FETCH_W must be 8 or 16");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            out_valid_q;
  op_e             out_op_q;
  logic            out_illegal_q;
  logic [15:0]     out_instr_q;
  logic [PC_W-1:0] out_pc_q;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  logic [15:0]     word_w;
  logic [PC_W-1:0] pc_w;
  logic            complete_w;
  logic            out_free_w;
  op_e             dec_op_w;
  logic            dec_illegal_w;

  assign out_free_w = !out_valid_q || out_ready;

  if (FETCH_W == 16) begin : g_w16
    assign in_ready   = out_free_w;
    assign word_w     = in_data;
    assign pc_w       = in_pc;
    assign complete_w = in_valid && out_free_w;
  end else begin : g_w8
    asm_state_e      state_q, state_d;
    logic [7:0]      hi_q;
    logic [PC_W-1:0] pc_q;
    logic            ready_w;
    logic            complete_d;

    always_comb begin
      state_d    = state_q;
      ready_w    = 1'b1;
      complete_d = 1'b0;
      case (state_q)
        S_HI: if (in_valid) state_d = S_LO;
        S_LO: begin
          ready_w = out_free_w;
          if (in_valid && out_free_w) begin
            complete_d = 1'b1;
            state_d    = S_HI;
          end
        end
        default: state_d = S_HI;
      endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        state_q <= S_HI;
        hi_q    <= '0;
        pc_q    <= '0;
      end else begin
        state_q <= state_d;
        if (in_valid && state_q == S_HI) begin
          hi_q <= in_data;
          pc_q <= in_pc;
        end
      end
    end

    assign in_ready   = ready_w;
    assign word_w     = {hi_q, in_data};
    assign pc_w       = pc_q;
    assign complete_w = complete_d;
  end

  instr_decode_comb #(.STRICT(STRICT)) u_decode (
    .instr_i  (word_w),
    .op_o     (dec_op_w),
    .illegal_o(dec_illegal_w)
  );

  always_comb begin
    illegal_cnt_d = illegal_cnt_q;
    if (complete_w && !flush && dec_illegal_w && illegal_cnt_q != CNT_MAX)
      illegal_cnt_d = illegal_cnt_q + 1'b1;
  end

  // Flush beats any load or unload; a load in the same cycle as an unload keeps out_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_op_q      <= OP_NONE;
      out_illegal_q <= 1'b0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
      illegal_cnt_q <= '0;
    end else begin
      illegal_cnt_q <= illegal_cnt_d;
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (complete_w) begin
        out_valid_q   <= 1'b1;
        out_op_q      <= dec_op_w;
        out_illegal_q <= dec_illegal_w;
        out_instr_q   <= word_w;
        out_pc_q      <= pc_w;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_op      = out_op_q;
  assign out_illegal = out_illegal_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign out_x       = out_instr_q[11:8];
  assign out_y       = out_instr_q[7:4];
  assign out_n       = out_instr_q[3:0];
  assign out_nn      = out_instr_q[7:0];
  assign out_nnn     = out_instr_q[11:0];
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_instr_decoder_pipe.sv
// Directed bench: a 16-bit permissive decoder (2-bit counter) and an 8-bit strict decoder side by side.
module tb_instr_decoder_pipe;
  import decoder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
  logic [15:0] a_in_data, a_out_instr;
  logic [11:0] a_in_pc, a_out_pc, a_out_nnn;
  logic [3:0]  a_out_x, a_out_y, a_out_n;
  logic [7:0]  a_out_nn;
  op_e         a_out_op;
  logic [1:0]  a_cnt;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [7:0]  b_in_data;
  logic [15:0] b_out_instr;
  logic [11:0] b_in_pc, b_out_pc, b_out_nnn;
  logic [3:0]  b_out_x, b_out_y, b_out_n;
  logic [7:0]  b_out_nn;
  op_e         b_out_op;
  logic [7:0]  b_cnt;

  instr_decoder_pipe #(.FETCH_W(16), .PC_W(12), .STRICT(1'b0), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_pc(a_in_pc),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_op(a_out_op),
    .out_x(a_out_x), .out_y(a_out_y), .out_n(a_out_n), .out_nn(a_out_nn), .out_nnn(a_out_nnn),
    .out_instr(a_out_instr), .out_pc(a_out_pc), .out_illegal(a_out_illegal), .illegal_cnt(a_cnt)
  );

  instr_decoder_pipe #(.FETCH_W(8), .PC_W(12), .STRICT(1'b1), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_op(b_out_op),
    .out_x(b_out_x), .out_y(b_out_y), .out_n(b_out_n), .out_nn(b_out_nn), .out_nnn(b_out_nnn),
    .out_instr(b_out_instr), .out_pc(b_out_pc), .out_illegal(b_out_illegal), .illegal_cnt(b_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two byte beats into dut_b with out_ready high; nothing may appear after the high byte.
  task automatic b_word(input logic [15:0] w, input logic [11:0] pc, input string tag);
    b_in_valid = 1'b1;
    b_in_data  = w[15:8];
    b_in_pc    = pc;
    tick();
    check({tag, " hi-beat no output"}, b_out_valid, 1'b0);
    b_in_data = w[7:0];
    b_in_pc   = 12'hFFF;
    tick();
    b_in_valid = 1'b0;
  endtask

  typedef struct {
    logic [15:0] instr;
    op_e         op;
    logic        ill;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{16'h8AB4, OP_ADD_REG, 1'b0};
    vecs[1]  = '{16'h00E0, OP_CLS,     1'b0};
    vecs[2]  = '{16'h00EE, OP_RET,     1'b0};
    vecs[3]  = '{16'h0123, OP_SYS,     1'b0};
    vecs[4]  = '{16'h1234, OP_JP,      1'b0};
    vecs[5]  = '{16'h2ABC, OP_CALL,    1'b0};
    vecs[6]  = '{16'h3A42, OP_SE_IMM,  1'b0};
    vecs[7]  = '{16'h5120, OP_SE_REG,  1'b0};
    vecs[8]  = '{16'h8125, OP_SUB,     1'b0};
    vecs[9]  = '{16'h812E, OP_SHL,     1'b0};
    vecs[10] = '{16'h8128, OP_NONE,    1'b1};
    vecs[11] = '{16'h9AB0, OP_SNE_REG, 1'b0};
    vecs[12] = '{16'h9AB1, OP_NONE,    1'b1};
    vecs[13] = '{16'hD125, OP_DRW,     1'b0};
    vecs[14] = '{16'hE19E, OP_SKP,     1'b0};
    vecs[15] = '{16'hE1A1, OP_SKNP,    1'b0};
    vecs[16] = '{16'hF107, OP_LD_VX_DT,1'b0};
    vecs[17] = '{16'hF10A, OP_LD_VX_K, 1'b0};
    vecs[18] = '{16'hF165, OP_LD_VX_I, 1'b0};
    vecs[19] = '{16'hF1FF, OP_NONE,    1'b1};
    vecs[20] = '{16'hF155, OP_LD_I_VX, 1'b0};

    rst = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_in_pc = '0; a_out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_pc = '0; b_out_ready = 1'b0;
    tick();
    tick();

    check("a reset out_valid", a_out_valid, 1'b0);
    check("a reset out_op", a_out_op, OP_NONE);
    check("a reset instr", a_out_instr, 16'h0000);
    check("a reset cnt", a_cnt, 2'd0);
    check("a reset in_ready", a_in_ready, 1'b1);
    check("b reset out_valid", b_out_valid, 1'b0);
    check("b reset cnt", b_cnt, 8'd0);
    check("b reset in_ready", b_in_ready, 1'b1);
    rst = 1'b0;
    tick();

    // Illegal stream and counter saturation on the 2-bit counter.
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    begin
      logic [15:0] ill_words [5];
      logic [1:0]  ill_cnt   [5];
      ill_words = '{16'h5121, 16'hE1FF, 16'h800F, 16'h5AB1, 16'h8AB9};
      ill_cnt   = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      for (int i = 0; i < 5; i++) begin
        a_in_data = ill_words[i];
        a_in_pc   = 12'h100;
        tick();
        check($sformatf("ill%0d valid", i), a_out_valid, 1'b1);
        check($sformatf("ill%0d illegal", i), a_out_illegal, 1'b1);
        check($sformatf("ill%0d op", i), a_out_op, OP_NONE);
        check($sformatf("ill%0d nnn", i), a_out_nnn, {20'h0, ill_words[i][11:0]});
        check($sformatf("ill%0d cnt", i), a_cnt, ill_cnt[i]);
      end
    end

    // Back-to-back decode table on the 16-bit instance.
    for (int i = 0; i < NV; i++) begin
      a_in_data = vecs[i].instr;
      a_in_pc   = 12'h200 + 12'(2 * i);
      tick();
      check($sformatf("vec%0d valid", i), a_out_valid, 1'b1);
      check($sformatf("vec%0d op %04h", i, vecs[i].instr), a_out_op, vecs[i].op);
      check($sformatf("vec%0d illegal", i), a_out_illegal, vecs[i].ill);
      check($sformatf("vec%0d x", i), a_out_x, vecs[i].instr[11:8]);
      check($sformatf("vec%0d y", i), a_out_y, vecs[i].instr[7:4]);
      check($sformatf("vec%0d n", i), a_out_n, vecs[i].instr[3:0]);
      check($sformatf("vec%0d nn", i), a_out_nn, vecs[i].instr[7:0]);
      check($sformatf("vec%0d nnn", i), a_out_nnn, vecs[i].instr[11:0]);
      check($sformatf("vec%0d instr", i), a_out_instr, vecs[i].instr);
      check($sformatf("vec%0d pc", i), a_out_pc, 12'h200 + 12'(2 * i));
    end
    a_in_valid = 1'b0;
    tick();
    check("a drained", a_out_valid, 1'b0);

    // Backpressure: 6A42 held while 7105 waits, then new word wins on the unload cycle.
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 16'h6A42;
    a_in_pc     = 12'h300;
    tick();
    check("bp first valid", a_out_valid, 1'b1);
    check("bp first op", a_out_op, OP_LD_IMM);
    a_in_data = 16'h7105;
    a_in_pc   = 12'h302;
    #1;
    check("bp in_ready low", a_in_ready, 1'b0);
    tick();
    check("bp held instr", a_out_instr, 16'h6A42);
    check("bp held pc", a_out_pc, 12'h300);
    check("bp held valid", a_out_valid, 1'b1);
    a_out_ready = 1'b1;
    #1;
    check("bp in_ready high", a_in_ready, 1'b1);
    tick();
    a_in_valid = 1'b0;
    check("bp second op", a_out_op, OP_ADD_IMM);
    check("bp second x", a_out_x, 4'h1);
    check("bp second nn", a_out_nn, 8'h05);
    check("bp second valid", a_out_valid, 1'b1);
    tick();
    check("bp drained", a_out_valid, 1'b0);

    // Byte-pair assembly on the 8-bit strict instance.
    b_out_ready = 1'b1;
    b_word(16'hD125, 12'h2F0, "drw");
    check("drw valid", b_out_valid, 1'b1);
    check("drw op", b_out_op, OP_DRW);
    check("drw x", b_out_x, 4'h1);
    check("drw y", b_out_y, 4'h2);
    check("drw n", b_out_n, 4'h5);
    check("drw instr", b_out_instr, 16'hD125);
    check("drw pc", b_out_pc, 12'h2F0);

    b_word(16'h0123, 12'h2F2, "strict sys");
    check("strict 0123 illegal", b_out_illegal, 1'b1);
    check("strict 0123 op", b_out_op, OP_NONE);
    check("strict 0123 nnn", b_out_nnn, 12'h123);
    check("strict cnt", b_cnt, 8'd1);
    b_word(16'h00E0, 12'h2F4, "strict cls");
    check("strict 00E0 op", b_out_op, OP_CLS);
    check("strict 00E0 illegal", b_out_illegal, 1'b0);

    // Flush discards a held high byte.
    b_in_valid = 1'b1;
    b_in_data  = 8'hA2;
    b_in_pc    = 12'h400;
    tick();
    b_in_valid = 1'b0;
    b_flush    = 1'b1;
    tick();
    b_flush = 1'b0;
    check("flush no output", b_out_valid, 1'b0);
    b_word(16'h1234, 12'h410, "flush jp");
    check("flush jp op", b_out_op, OP_JP);
    check("flush jp nnn", b_out_nnn, 12'h234);
    check("flush jp instr", b_out_instr, 16'h1234);
    check("flush jp pc", b_out_pc, 12'h410);

    // Flush clears a stalled output and drops a beat accepted in the same cycle.
    b_out_ready = 1'b0;
    tick();
    check("stall valid", b_out_valid, 1'b1);
    b_in_valid = 1'b1;
    b_in_data  = 8'h56;
    b_flush    = 1'b1;
    tick();
    b_flush    = 1'b0;
    b_in_valid = 1'b0;
    check("flush clears valid", b_out_valid, 1'b0);
    check("flush keeps cnt", b_cnt, 8'd1);
    b_out_ready = 1'b1;
    b_word(16'h6B07, 12'h420, "after flush");
    check("after flush instr", b_out_instr, 16'h6B07);
    check("after flush op", b_out_op, OP_LD_IMM);

    // Reset mid-assembly behaves like flush and also clears the counter.
    b_in_valid = 1'b1;
    b_in_data  = 8'hA2;
    b_in_pc    = 12'h500;
    tick();
    b_in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst no output", b_out_valid, 1'b0);
    check("rst cnt", b_cnt, 8'd0);
    b_word(16'h1234, 12'h510, "rst jp");
    check("rst jp op", b_out_op, OP_JP);
    check("rst jp nnn", b_out_nnn, 12'h234);
    check("rst jp instr", b_out_instr, 16'h1234);
    check("rst jp pc", b_out_pc, 12'h510);
    tick();
    check("rst jp drained", b_out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
